// File: rtl/ncl_wavefront_source_if.sv
// rtl/ncl_wavefront_source_if.sv - word-in / result-out handshake bundle for the wavefront source
interface ncl_wavefront_source_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/ncl_wavefront_source.sv
// rtl/ncl_wavefront_source.sv - drives dual-rail DATA/NULL wavefronts into an NCL gate stage and captures its result
module ncl_wavefront_source #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    ncl_wavefront_source_if.slave bus,
    output logic [WIDTH-1:0]      rail1,
    output logic [WIDTH-1:0]      rail0,
    input  logic                  ko,
    input  logic                  res1,
    input  logic                  res0,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic [15:0]           wave_count
);
    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [1:0] {IDLE, WAIT_DATA, WAIT_NULL, ERR} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rail1_q, rail1_d, rail0_q, rail0_d;
    logic             out_valid_q, out_valid_d, out_data_q, out_data_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [15:0]      wave_count_q, wave_count_d, timer_q, timer_d;
    logic [SS-1:0]    ko_sync_q, ko_sync_d, r1_sync_q, r1_sync_d, r0_sync_q, r0_sync_d;

    logic ko_s, r1_s, r0_s;
    logic accept, illegal, data_done, null_done, timed_out;

    assign ko_s = ko_sync_q[SS-1];
    assign r1_s = r1_sync_q[SS-1];
    assign r0_s = r0_sync_q[SS-1];

    assign ko_sync_d = {ko_sync_q[SS-2:0], ko};
    assign r1_sync_d = {r1_sync_q[SS-2:0], res1};
    assign r0_sync_d = {r0_sync_q[SS-2:0], res0};

    assign accept    = bus.in_valid && bus.in_ready;
    assign illegal   = r1_s && r0_s;
    assign data_done = !ko_s && (r1_s ^ r0_s);
    assign null_done = ko_s && !r1_s && !r0_s;
    assign timed_out = timer_q >= 16'(TIMEOUT);

    // Rails are registers with async clear so a reset pulls them to NULL without waiting for clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rail1_q      <= '0;
            rail0_q      <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 1'b0;
            err_code_q   <= 2'b00;
            wave_count_q <= '0;
            timer_q      <= '0;
            ko_sync_q    <= '0;
            r1_sync_q    <= '0;
            r0_sync_q    <= '0;
        end else begin
            state_q      <= state_d;
            rail1_q      <= rail1_d;
            rail0_q      <= rail0_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            err_code_q   <= err_code_d;
            wave_count_q <= wave_count_d;
            timer_q      <= timer_d;
            ko_sync_q    <= ko_sync_d;
            r1_sync_q    <= r1_sync_d;
            r0_sync_q    <= r0_sync_d;
        end
    end

    // Illegal code outranks completion, and completion outranks timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept) state_d = WAIT_DATA;
            WAIT_DATA: begin
                if (illegal)        state_d = ERR;
                else if (data_done) state_d = WAIT_NULL;
                else if (timed_out) state_d = ERR;
            end
            WAIT_NULL: begin
                if (null_done)      state_d = IDLE;
                else if (timed_out) state_d = ERR;
            end
            default:   state_d = ERR;
        endcase
    end

    always_comb begin
        rail1_d      = '0;
        rail0_d      = '0;
        out_valid_d  = 1'b0;
        out_data_d   = out_data_q;
        err_code_d   = err_code_q;
        wave_count_d = wave_count_q;
        timer_d      = '0;
        if (state_d == WAIT_DATA) begin
            rail1_d = accept ? bus.in_data  : rail1_q;
            rail0_d = accept ? ~bus.in_data : rail0_q;
        end
        if (state_q == WAIT_DATA && state_d == WAIT_NULL) begin
            out_valid_d = 1'b1;
            out_data_d  = r1_s;
        end
        if (state_q == WAIT_NULL && state_d == IDLE) begin
            wave_count_d = wave_count_q + 16'd1;
        end
        if (state_q != ERR && state_d == ERR) begin
            err_code_d = (state_q == WAIT_DATA && illegal) ? 2'b10 : 2'b01;
        end
        if (state_d == state_q && (state_q == WAIT_DATA || state_q == WAIT_NULL)) begin
            timer_d = timer_q + 16'd1;
        end
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE) && ko_s && !r1_s && !r0_s;
        bus.out_valid = out_valid_q;
        bus.out_data  = out_data_q;
        err           = (state_q == ERR);
        err_code      = err_code_q;
        wave_count    = wave_count_q;
        rail1         = rail1_q;
        rail0         = rail0_q;
    end
endmodule

// File: doc/ncl_wavefront_source.md
Name: ncl_wavefront_source

Overview:
- Clocked stimulus/capture stage that sits directly upstream of a single-output NCL threshold-gate stage, such as a 4-input weighted threshold gate.
- Accepts binary words on a valid/ready interface and encodes each word as a dual-rail DATA wavefront on the gate inputs.
- Waits for downstream completion, captures the dual-rail result, then drives a NULL wavefront and waits for the stage to return to NULL.
- Detects handshake timeouts and illegal dual-rail codes.

Parameters:
- WIDTH, 4: number of dual-rail input signals driven.
- SYNC_STAGES, 2: flops in the ko synchronizer; minimum 2.
- TIMEOUT, 255: maximum cycles spent in any wait state before error; the timer is 16 bits wide.

Ports:
- clk  input  1  single clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream word available.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  WIDTH  binary word to encode.
- rail1  output  WIDTH  dual-rail true rails to the gate stage.
- rail0  output  WIDTH  dual-rail false rails to the gate stage.
- ko  input  1  downstream completion, asynchronous: 1 = request-for-data, 0 = request-for-null.
- res1  input  1  result true rail from the gate stage, asynchronous.
- res0  input  1  result false rail from the gate stage, asynchronous.
- out_valid  output  1  one-cycle pulse when a result is captured.
- out_data  output  1  captured result bit.
- err  output  1  sticky error flag.
- err_code  output  2  error cause: 01 = timeout, 10 = illegal result code (res1 = res0 = 1).
- wave_count  output  16  completed DATA+NULL cycles, wrapping.

Behaviour:
- Reset (async, rst = 1): state IDLE; rail1, rail0, out_valid, out_data, err, err_code, wave_count, timer and synchronizers all 0; in_ready = 0.
- ko, res1 and res0 each pass through a SYNC_STAGES flop synchronizer. All decisions use the synchronized values (ko_s, r1_s, r0_s).

State IDLE:
- rails are NULL (all 0).
- in_ready = 1 only when ko_s = 1, r1_s = 0 and r0_s = 0.
- A transfer occurs when in_valid & in_ready. On transfer:
  - register rail1 <= in_data, rail0 <= ~in_data;
  - go to WAIT_DATA;
  - clear the timer.
- DATA appears on the rails on the first clk edge after acceptance (1-cycle latency).

State WAIT_DATA:
- Rails are held stable.
- Exit condition: ko_s = 0 and exactly one of r1_s/r0_s is high. On exit:
  - out_data <= r1_s and out_valid = 1 for one cycle;
  - rails <= all 0;
  - go to WAIT_NULL.
- If r1_s & r0_s: go to ERR with err_code = 10. This check has priority over the exit condition.

State WAIT_NULL:
- Rails are held at 0.
- Exit condition: ko_s = 1, r1_s = 0 and r0_s = 0. On exit:
  - wave_count increments, wrapping from 0xFFFF to 0;
  - go to IDLE.
- in_ready stays 0 until IDLE is re-entered, so there is a minimum of one idle cycle between words.

Timer:
- Increments every cycle in WAIT_DATA and WAIT_NULL; cleared on every state change.
- When the timer reaches TIMEOUT without the exit condition: go to ERR with err_code = 01.
- If the exit condition and the timeout occur in the same cycle, the exit condition wins.

State ERR:
- Rails forced to all 0; in_ready = 0; err = 1.
- Absorbing: only rst leaves ERR.
- err_code holds the first cause only.

Other rules:
- Rails only ever change as NULL -> DATA -> NULL. No two rails of the same bit are ever high together, and no DATA -> DATA transition occurs.
- in_data is sampled only on transfer. Changes while busy are ignored.
- Reset asserted mid-wavefront drives the rails to NULL immediately (asynchronously) and discards the pending result; out_valid is not pulsed.

Test Plan:
- Reset, then ko = 1 with result NULL -> in_ready = 1 after SYNC_STAGES+1 cycles. rail1 = 0000, rail0 = 0000, err = 0.
- Accept in_data = 1011, model ko -> 0 and res1 = 1 after 3 cycles -> rail1 = 1011 and rail0 = 0100 one cycle after accept. out_valid pulses once with out_data = 1. Rails go to 0 the cycle after capture. After ko -> 1 and res = NULL, wave_count = 1.
- 5 back-to-back words with in_valid held high -> exactly 5 out_valid pulses, wave_count = 5. in_ready is low from acceptance through WAIT_NULL for each word.
- Downstream never lowers ko after accept -> err = 1 and err_code = 01 after 255 cycles in WAIT_DATA. Rails are all 0 and in_ready stays 0 until rst.
- Drive res1 = res0 = 1 in WAIT_DATA -> err_code = 10, no out_valid. Drive the same code with ko_s = 0 in the same cycle -> err_code = 10 still wins.
- Assert rst while in WAIT_DATA with rails = 1011/0100 -> rails go to 0 before the next clk edge. After release, wave_count = 0 and a new word is accepted normally.
